// File: rtl/muldiv_ctrl.sv
// ============================================================================
// muldiv_ctrl
// ----------------------------------------------------------------------------
// Sequencer for the EX-stage multi-cycle multiplier and divider, and owner of
// the architectural HI/LO register pair.
//
// One operation is launched per EX instruction. The pipeline is held with
// stall_req until the launched unit reports done. The 64-bit result is then
// committed to HI/LO, and a single HOLD cycle lets the instruction leave EX.
// The block also handles EX flushes, divide-by-zero skipping, watchdog
// timeouts and mthi/mtlo writes.
//
// Parameters
//   TIMEOUT     cycles allowed in RUN before the operation is abandoned
//   DIV0_SKIP   nonzero: DIV/DIVU with a zero divisor never starts the divider
//
// Ports
//   clk, rst                  clock (rising edge), async reset (active low)
//   op_valid, op_kind         EX holds MULT(00)/MULTU(01)/DIV(10)/DIVU(11)
//   src_a, src_b              rs / rt operands
//   flushE                    EX flush, kills the in-flight operation
//   hi_we, lo_we, hilo_wdata  mthi / mtlo write port
//   mul_start, div_start      one-cycle start pulses to the units
//   unit_sign, unit_a, unit_b latched operation attributes for the units
//   unit_cancel               one-cycle cancel pulse to the active unit
//   mul_done, mul_result      multiplier completion and {hi,lo} product
//   div_done, div_result      divider completion and {remainder,quotient}
//   stall_req                 hold IF/ID/EX
//   hilo                      architectural {HI,LO}
//   div_by_zero, err_timeout  one-cycle status flags
// ============================================================================
module muldiv_ctrl #(
   parameter int TIMEOUT   = 64,
   parameter int DIV0_SKIP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [1:0]  op_kind,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flushE,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] hilo_wdata,
   output logic        mul_start,
   output logic        div_start,
   output logic        unit_sign,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        unit_cancel,
   input  logic        mul_done,
   input  logic [63:0] mul_result,
   input  logic        div_done,
   input  logic [63:0] div_result,
   output logic        stall_req,
   output logic [63:0] hilo,
   output logic        div_by_zero,
   output logic        err_timeout
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;
   logic          run_div;
   logic          launch;
   logic          skip_div0;
   logic          unit_done;
   logic          commit;
   logic          abort_flush;
   logic          abort_timeout;

   // Next-state and stall decode.
   // The done of the unit that was not launched is ignored. Done is also
   // ignored in the first RUN cycle, because the start pulse is still on the
   // wire then, so a done level left over from an earlier operation cannot
   // commit early. A flush beats a same-cycle done, since the instruction is
   // dead. A done beats a same-cycle timeout.
   // stall_req is forced low while reset is asserted so that every output
   // reads zero during reset, even when op_valid is high.
   always_comb begin
      state_next    = state;
      launch        = 1'b0;
      skip_div0     = 1'b0;
      commit        = 1'b0;
      abort_flush   = 1'b0;
      abort_timeout = 1'b0;
      stall_req     = 1'b0;
      unit_done     = run_div ? div_done : mul_done;

      case (state)
         IDLE: begin
            if (op_valid && !flushE) begin
               stall_req = 1'b1;
               if ((DIV0_SKIP != 0) && op_kind[1] && (src_b == 32'd0)) begin
                  skip_div0  = 1'b1;
                  state_next = HOLD;
               end else begin
                  launch     = 1'b1;
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (flushE) begin
               abort_flush = 1'b1;
               state_next  = IDLE;
            end else begin
               stall_req = 1'b1;
               if (unit_done && (cnt != '0)) begin
                  commit     = 1'b1;
                  state_next = HOLD;
               end else if (cnt == CW'(TIMEOUT)) begin
                  abort_timeout = 1'b1;
                  state_next    = IDLE;
               end
            end
         end
         HOLD: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (!rst) begin
         stall_req = 1'b0;
      end
   end

   // State, run counter, operand latches and one-cycle pulses.
   // The counter restarts at zero on every entry to RUN, so it counts the
   // cycles spent waiting on the current operation only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         run_div     <= 1'b0;
         unit_sign   <= 1'b0;
         unit_a      <= 32'd0;
         unit_b      <= 32'd0;
         mul_start   <= 1'b0;
         div_start   <= 1'b0;
         unit_cancel <= 1'b0;
         div_by_zero <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= ((state == RUN) && (state_next == RUN)) ? cnt + CW'(1) : '0;
         mul_start   <= launch & ~op_kind[1];
         div_start   <= launch & op_kind[1];
         unit_cancel <= abort_flush | abort_timeout;
         div_by_zero <= skip_div0;
         err_timeout <= abort_timeout;
         if (launch) begin
            unit_a    <= src_a;
            unit_b    <= src_b;
            unit_sign <= ~op_kind[0];
            run_div   <= op_kind[1];
         end
      end
   end

   // HI/LO register.
   // A unit commit on the same edge as an mthi/mtlo write takes priority,
   // because the mul/div instruction is the younger of the two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hilo <= 64'd0;
      end else if (commit) begin
         hilo <= run_div ? div_result : mul_result;
      end else begin
         if (hi_we) begin
            hilo[63:32] <= hilo_wdata;
         end
         if (lo_we) begin
            hilo[31:0] <= hilo_wdata;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ============================================================================
// tb_muldiv_ctrl
// ----------------------------------------------------------------------------
// Directed bench for muldiv_ctrl. The bench plays the role of the multiplier
// and divider: it drives done/result by hand and checks the sequencer
// against hand-computed values. Inputs change on the falling edge, and
// outputs are sampled 1 ns later.
// ============================================================================
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [1:0]  op_kind;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flushE;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] hilo_wdata;
   logic        mul_start;
   logic        div_start;
   logic        unit_sign;
   logic [31:0] unit_a;
   logic [31:0] unit_b;
   logic        unit_cancel;
   logic        mul_done;
   logic [63:0] mul_result;
   logic        div_done;
   logic [63:0] div_result;
   logic        stall_req;
   logic [63:0] hilo;
   logic        div_by_zero;
   logic        err_timeout;

   int check_count = 0;
   int fail_count  = 0;
   int mul_start_count = 0;
   int div_start_count = 0;

   muldiv_ctrl #(
      .TIMEOUT   (8),
      .DIV0_SKIP (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .op_valid    (op_valid),
      .op_kind     (op_kind),
      .src_a       (src_a),
      .src_b       (src_b),
      .flushE      (flushE),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .hilo_wdata  (hilo_wdata),
      .mul_start   (mul_start),
      .div_start   (div_start),
      .unit_sign   (unit_sign),
      .unit_a      (unit_a),
      .unit_b      (unit_b),
      .unit_cancel (unit_cancel),
      .mul_done    (mul_done),
      .mul_result  (mul_result),
      .div_done    (div_done),
      .div_result  (div_result),
      .stall_req   (stall_req),
      .hilo        (hilo),
      .div_by_zero (div_by_zero),
      .err_timeout (err_timeout)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Count start pulses, one per high cycle, to prove they are single pulses
   always @(negedge clk) begin
      if (mul_start) mul_start_count <= mul_start_count + 1;
      if (div_start) div_start_count <= div_start_count + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [1:0] kind,
                                input logic [31:0] a, input logic [31:0] b);
      op_valid = valid;
      op_kind  = kind;
      src_a    = a;
      src_b    = b;
   endtask

   // Advance to the next falling edge, where the next cycle's inputs are set
   task automatic nextCycle();
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b0;
      flushE     = 1'b0;
      hi_we      = 1'b0;
      lo_we      = 1'b0;
      hilo_wdata = 32'd0;
      mul_done   = 1'b0;
      mul_result = 64'd0;
      div_done   = 1'b0;
      div_result = 64'd0;
      applyStimulus(1'b1, 2'b00, 32'h1111_1111, 32'h2222_2222);

      // ---------------- reset state, op_valid high during reset --------
      repeat (2) nextCycle();
      #1;
      checkOutput("rst_stall",  64'(stall_req), 64'd0);
      checkOutput("rst_hilo",   hilo, 64'd0);
      checkOutput("rst_unit_a", 64'(unit_a), 64'd0);
      checkOutput("rst_pulses", 64'({mul_start, div_start, unit_cancel, div_by_zero, err_timeout}), 64'd0);
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
      rst = 1'b1;

      // ---------------- MULT 0xFFFFFFFE * 3 = -6 -----------------------
      nextCycle();
      applyStimulus(1'b1, 2'b00, 32'hFFFF_FFFE, 32'd3);
      #1 checkOutput("mult_stall_c0", 64'(stall_req), 64'd1);
      nextCycle();
      #1;
      checkOutput("mult_start",    64'(mul_start), 64'd1);
      checkOutput("mult_no_div",   64'(div_start), 64'd0);
      checkOutput("mult_operands", {unit_a, unit_b}, {32'hFFFF_FFFE, 32'd3});
      checkOutput("mult_sign",     64'(unit_sign), 64'd1);
      nextCycle();
      #1 checkOutput("mult_stall_c2", 64'({stall_req, mul_start}), 64'b10);
      nextCycle();
      #1 checkOutput("mult_stall_c3", 64'(stall_req), 64'd1);
      nextCycle();
      mul_done   = 1'b1;
      mul_result = 64'hFFFF_FFFF_FFFF_FFFA;
      #1;
      checkOutput("mult_stall_c4", 64'(stall_req), 64'd1);
      checkOutput("mult_hilo_pre", hilo, 64'd0);
      nextCycle();
      mul_done = 1'b0;
      #1;
      checkOutput("mult_hold_stall", 64'(stall_req), 64'd0);
      checkOutput("mult_hilo",       hilo, 64'hFFFF_FFFF_FFFF_FFFA);
      nextCycle();
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
      #1;
      checkOutput("mult_no_relaunch", 64'({mul_start, stall_req}), 64'd0);

      // ---------------- DIVU 7 / 2, stray mul_done ignored -------------
      nextCycle();
      applyStimulus(1'b1, 2'b11, 32'd7, 32'd2);
      #1 checkOutput("divu_stall_c0", 64'(stall_req), 64'd1);
      nextCycle();
      #1;
      checkOutput("divu_starts", 64'({mul_start, div_start}), 64'b01);
      checkOutput("divu_sign",   64'(unit_sign), 64'd0);
      nextCycle();
      mul_done   = 1'b1;
      mul_result = 64'hDEAD_BEEF_DEAD_BEEF;
      #1 checkOutput("divu_div_start_off", 64'(div_start), 64'd0);
      nextCycle();
      mul_done   = 1'b0;
      div_done   = 1'b1;
      div_result = {32'd1, 32'd3};
      #1;
      checkOutput("divu_ignore_mul", 64'(stall_req), 64'd1);
      checkOutput("divu_hilo_pre",   hilo, 64'hFFFF_FFFF_FFFF_FFFA);
      nextCycle();
      div_done = 1'b0;
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
      #1;
      checkOutput("divu_hilo",    hilo, {32'd1, 32'd3});
      checkOutput("divu_hold",    64'(stall_req), 64'd0);
      checkOutput("divu_pulses",  64'({mul_start_count[7:0], div_start_count[7:0]}), {48'd0, 8'd1, 8'd1});

      // ---------------- DIV by zero is skipped --------------------------
      nextCycle();
      applyStimulus(1'b1, 2'b10, 32'd5, 32'd0);
      #1 checkOutput("div0_stall_c0", 64'(stall_req), 64'd1);
      nextCycle();
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
      #1;
      checkOutput("div0_flag",  64'({div_by_zero, div_start, stall_req}), 64'b100);
      nextCycle();
      #1;
      checkOutput("div0_flag_clear", 64'(div_by_zero), 64'd0);
      checkOutput("div0_hilo",       hilo, {32'd1, 32'd3});
      checkOutput("div0_no_start",   64'(div_start_count), 64'd1);

      // ---------------- flushE two cycles into RUN ----------------------
      nextCycle();
      applyStimulus(1'b1, 2'b11, 32'd100, 32'd7);
      nextCycle();
      nextCycle();
      flushE = 1'b1;
      #1 checkOutput("flush_stall_drop", 64'(stall_req), 64'd0);
      nextCycle();
      flushE = 1'b0;
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
      #1 checkOutput("flush_cancel", 64'({unit_cancel, stall_req}), 64'b10);
      nextCycle();
      div_done   = 1'b1;
      div_result = 64'h0000_0002_0000_000E;
      #1 checkOutput("flush_cancel_off", 64'(unit_cancel), 64'd0);
      nextCycle();
      div_done = 1'b0;
      #1 checkOutput("flush_hilo", hilo, {32'd1, 32'd3});

      // ---------------- mtlo on the same edge as a mul commit -----------
      nextCycle();
      applyStimulus(1'b1, 2'b01, 32'd1, 32'd5);
      nextCycle();
      nextCycle();
      mul_done   = 1'b1;
      mul_result = 64'h0000_0000_0000_0005;
      lo_we      = 1'b1;
      hilo_wdata = 32'h0000_1234;
      nextCycle();
      mul_done = 1'b0;
      lo_we    = 1'b0;
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
      #1 checkOutput("commit_beats_mtlo", hilo, 64'h0000_0000_0000_0005);
      nextCycle();
      hi_we      = 1'b1;
      hilo_wdata = 32'hCAFE_BABE;
      #1 checkOutput("mthi_not_yet", hilo, 64'h0000_0000_0000_0005);
      nextCycle();
      hi_we = 1'b0;
      #1 checkOutput("mthi_idle", hilo, 64'hCAFE_BABE_0000_0005);

      // ---------------- watchdog timeout, TIMEOUT = 8 -------------------
      nextCycle();
      applyStimulus(1'b1, 2'b00, 32'd9, 32'd9);
      for (int k = 1; k <= 9; k++) begin
         nextCycle();
         #1 checkOutput($sformatf("tmo_wait_%0d", k), 64'({stall_req, err_timeout}), 64'b10);
      end
      nextCycle();
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
      #1;
      checkOutput("tmo_flags", 64'({err_timeout, unit_cancel, stall_req}), 64'b110);
      checkOutput("tmo_hilo",  hilo, 64'hCAFE_BABE_0000_0005);
      nextCycle();
      #1 checkOutput("tmo_flags_clear", 64'({err_timeout, unit_cancel}), 64'd0);

      // ---------------- async reset mid-RUN -----------------------------
      nextCycle();
      applyStimulus(1'b1, 2'b00, 32'd3, 32'd4);
      nextCycle();
      nextCycle();
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("arst_hilo",    hilo, 64'd0);
      checkOutput("arst_outputs", 64'({stall_req, mul_start, unit_cancel, unit_a}), 64'd0);
      mul_done   = 1'b1;
      mul_result = 64'h0000_0000_0000_000C;
      nextCycle();
      rst = 1'b1;
      nextCycle();
      nextCycle();
      mul_done = 1'b0;
      #1 checkOutput("arst_no_accept", {hilo[62:0], stall_req}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
